// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter that shares one registered gate unit between two requesters,
// issuing a single operand at a time and returning the tagged result after LAT cycles.
module gate_unit_arbiter #(
    parameter int unsigned LAT        = 1,
    parameter bit          START_PRIO = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic [3:0] DATA0,
    input  logic       REQ1,
    input  logic [3:0] DATA1,
    output logic       GNT0,
    output logic       GNT1,
    output logic [3:0] IN_BUS,
    input  logic [2:0] RES_IN,
    output logic [2:0] RES,
    output logic       RES_ID,
    output logic       RES_VALID,
    output logic       BUSY
);

    localparam logic [2:0] LAT_CNT = 3'(LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t     state_r, state_nx;
    logic       prio_r, prio_nx;
    logic       owner_r, owner_nx;
    logic [2:0] cnt_r, cnt_nx;
    logic [3:0] in_bus_r, in_bus_nx;
    logic [2:0] res_r, res_nx;
    logic       res_id_r, res_id_nx;
    logic       res_valid_r, res_valid_nx;
    logic       gnt0_r, gnt0_nx;
    logic       gnt1_r, gnt1_nx;
    logic       winner_s;

    // With both requesting the priority holder wins, otherwise the lone requester.
    function automatic logic pick_winner(input logic req0, input logic req1, input logic prio);
        logic w;
        if (req0 && req1) begin
            w = prio;
        end else begin
            w = req1;
        end
        return w;
    endfunction

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            prio_r      <= START_PRIO;
            owner_r     <= 1'b0;
            cnt_r       <= 3'd0;
            in_bus_r    <= 4'd0;
            res_r       <= 3'd0;
            res_id_r    <= 1'b0;
            res_valid_r <= 1'b0;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            prio_r      <= prio_nx;
            owner_r     <= owner_nx;
            cnt_r       <= cnt_nx;
            in_bus_r    <= in_bus_nx;
            res_r       <= res_nx;
            res_id_r    <= res_id_nx;
            res_valid_r <= res_valid_nx;
            gnt0_r      <= gnt0_nx;
            gnt1_r      <= gnt1_nx;
        end
    end

    // Next-state and next-output decode; pulses default low, everything else holds.
    always_comb begin
        state_nx     = state_r;
        prio_nx      = prio_r;
        owner_nx     = owner_r;
        cnt_nx       = cnt_r;
        in_bus_nx    = in_bus_r;
        res_nx       = res_r;
        res_id_nx    = res_id_r;
        res_valid_nx = 1'b0;
        gnt0_nx      = 1'b0;
        gnt1_nx      = 1'b0;
        winner_s     = pick_winner(REQ0, REQ1, prio_r);
        case (state_r)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    in_bus_nx = winner_s ? DATA1 : DATA0;
                    gnt0_nx   = ~winner_s;
                    gnt1_nx   = winner_s;
                    owner_nx  = winner_s;
                    prio_nx   = ~winner_s;
                    state_nx  = ISSUE;
                end else begin
                    state_nx = IDLE;
                end
            end
            ISSUE: begin
                cnt_nx   = 3'd1;
                state_nx = WAIT;
            end
            WAIT: begin
                // cnt reaches LAT in the cycle the gate unit output reflects IN_BUS.
                if (cnt_r == LAT_CNT) begin
                    res_nx       = RES_IN;
                    res_id_nx    = owner_r;
                    res_valid_nx = 1'b1;
                    state_nx     = IDLE;
                end else begin
                    cnt_nx = cnt_r + 3'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign GNT0      = gnt0_r;
    assign GNT1      = gnt1_r;
    assign IN_BUS    = in_bus_r;
    assign RES       = res_r;
    assign RES_ID    = res_id_r;
    assign RES_VALID = res_valid_r;
    assign BUSY      = (state_r != IDLE);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Two arbiter builds (LAT=1/START_PRIO=0 and LAT=3/START_PRIO=1) driven with the same
// stimulus, each against a transaction-timing reference model and a gate-unit model.
module tb_gate_unit_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0, req1;
    logic [3:0]      data0, data1;
    logic [1:0]      gnt0, gnt1, res_id, res_valid, busy;
    logic [1:0][3:0] in_bus;
    logic [1:0][2:0] res, res_in;

    logic [2:0] pa1 = 3'd0;
    logic [2:0] pb1 = 3'd0, pb2 = 3'd0, pb3 = 3'd0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int         lat_m [2];
    bit         sp_m [2];
    int         g_cyc [2];
    int         next_free [2];
    bit         prio_m [2];
    bit         win_m [2];
    logic [3:0] bus_m [2];
    logic [2:0] res_m [2];
    bit         id_m [2];

    always #5 clk = ~clk;

    gate_unit_arbiter #(.LAT(1), .START_PRIO(1'b0)) dut_a (
        .CLK(clk), .RST(rst), .REQ0(req0), .DATA0(data0), .REQ1(req1), .DATA1(data1),
        .GNT0(gnt0[0]), .GNT1(gnt1[0]), .IN_BUS(in_bus[0]), .RES_IN(res_in[0]),
        .RES(res[0]), .RES_ID(res_id[0]), .RES_VALID(res_valid[0]), .BUSY(busy[0])
    );

    gate_unit_arbiter #(.LAT(3), .START_PRIO(1'b1)) dut_b (
        .CLK(clk), .RST(rst), .REQ0(req0), .DATA0(data0), .REQ1(req1), .DATA1(data1),
        .GNT0(gnt0[1]), .GNT1(gnt1[1]), .IN_BUS(in_bus[1]), .RES_IN(res_in[1]),
        .RES(res[1]), .RES_ID(res_id[1]), .RES_VALID(res_valid[1]), .BUSY(busy[1])
    );

    // {OUT3, OUT2, OUT1} = {OR(IN2,IN3), NAND(IN2,IN3), NOR(IN1,IN2)}
    function automatic logic [2:0] gate_fn(input logic [3:0] d);
        return {d[1] | d[2], ~(d[1] & d[2]), ~(d[0] | d[1])};
    endfunction

    // Gate units with one and three register stages.
    always @(posedge clk) begin
        pa1 <= gate_fn(in_bus[0]);
        pb1 <= gate_fn(in_bus[1]);
        pb2 <= pb1;
        pb3 <= pb2;
    end
    assign res_in[0] = pa1;
    assign res_in[1] = pb3;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            g_cyc[i]     = -100;
            next_free[i] = 0;
            prio_m[i]    = sp_m[i];
            win_m[i]     = 1'b0;
            bus_m[i]     = 4'd0;
            res_m[i]     = 3'd0;
            id_m[i]      = 1'b0;
        end
    endtask

    // Edge e: a result issued at cycle g lands at cycle g+LAT+1; arbitration reopens at edge g+LAT+2.
    task automatic model_edge(input int e);
        for (int i = 0; i < 2; i++) begin
            if (e == g_cyc[i] + lat_m[i] + 1) begin
                res_m[i] = gate_fn(bus_m[i]);
                id_m[i]  = win_m[i];
            end
            if (e >= next_free[i] && (req0 || req1)) begin
                win_m[i]     = (req0 && req1) ? prio_m[i] : req1;
                prio_m[i]    = ~win_m[i];
                bus_m[i]     = win_m[i] ? data1 : data0;
                g_cyc[i]     = e;
                next_free[i] = e + lat_m[i] + 2;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic eg0, eg1, eb, ev;
            eg0 = (cyc == g_cyc[i]) && !win_m[i];
            eg1 = (cyc == g_cyc[i]) && win_m[i];
            eb  = (cyc >= g_cyc[i]) && (cyc <= g_cyc[i] + lat_m[i]);
            ev  = (cyc == g_cyc[i] + lat_m[i] + 1);
            check($sformatf("d%0d_gnt", i), {6'd0, gnt0[i], gnt1[i]}, {6'd0, eg0, eg1});
            check($sformatf("d%0d_busy", i), {7'd0, busy[i]}, {7'd0, eb});
            check($sformatf("d%0d_res_valid", i), {7'd0, res_valid[i]}, {7'd0, ev});
            check($sformatf("d%0d_in_bus", i), {4'd0, in_bus[i]}, {4'd0, bus_m[i]});
            check($sformatf("d%0d_res", i), {5'd0, res[i]}, {5'd0, res_m[i]});
            check($sformatf("d%0d_res_id", i), {7'd0, res_id[i]}, {7'd0, id_m[i]});
        end
    endtask

    task automatic step(input logic r0, input logic [3:0] d0, input logic r1, input logic [3:0] d1);
        @(negedge clk);
        check_all();
        req0  = r0;
        data0 = d0;
        req1  = r1;
        data1 = d1;
    endtask

    // Reset lands between edges, so outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        check_all();
        #2 rst = 1'b1;
        #1;
        reset_model();
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) model_edge(cyc);
        end
    end

    initial begin
        lat_m[0] = 1;
        lat_m[1] = 3;
        sp_m[0]  = 1'b0;
        sp_m[1]  = 1'b1;
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 4'd0;
        data1 = 4'd0;
        reset_model();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        for (int k = 0; k < 12; k++) step(1'b1, 4'b0000, 1'b0, 4'b0000);
        for (int k = 0; k < 10; k++) step(1'b0, 4'b0000, 1'b1, 4'b0110);
        for (int k = 0; k < 10; k++) step(1'b0, 4'b0000, 1'b1, 4'b0001);
        for (int k = 0; k < 36; k++) step(1'b1, 4'b0000, 1'b1, 4'b0110);
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0000, 1'b0, 4'b0000);
        step(1'b1, 4'b0000, 1'b1, 4'b0110);
        step(1'b1, 4'b0000, 1'b1, 4'b0110);
        step(1'b0, 4'b0000, 1'b0, 4'b0000);
        do_reset();
        for (int k = 0; k < 12; k++) step(1'b1, 4'b0000, 1'b1, 4'b0110);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom));
            end
        end
        for (int k = 0; k < 8; k++) step(1'b0, 4'b0000, 1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
